// File: rtl/p_readport_pkg.sv
// ---------------------------------------------------------------------------
// p_readport_pkg -- shared tube definitions for the parasite read port.
//   rp_state_e   : read-port FSM state encoding
//   ADDR_*       : parasite-side address map (even = status, odd = data)
//   REG_R*       : register indices n = addr[2:1]
//   reg_onehot() : one-hot FIFO select for register index n
// ---------------------------------------------------------------------------
package p_readport_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STROBE = 2'd2
    } rp_state_e;

    // Address map: bit 0 selects data (1) or status (0), bits 2:1 the register.
    localparam logic [2:0] ADDR_R1_STATUS = 3'd0;
    localparam logic [2:0] ADDR_R1_DATA   = 3'd1;
    localparam logic [2:0] ADDR_R2_STATUS = 3'd2;
    localparam logic [2:0] ADDR_R2_DATA   = 3'd3;
    localparam logic [2:0] ADDR_R3_STATUS = 3'd4;
    localparam logic [2:0] ADDR_R3_DATA   = 3'd5;
    localparam logic [2:0] ADDR_R4_STATUS = 3'd6;
    localparam logic [2:0] ADDR_R4_DATA   = 3'd7;

    localparam int unsigned ADDR_DATA_BIT = 0;

    localparam logic [1:0] REG_R1 = 2'd0;
    localparam logic [1:0] REG_R2 = 2'd1;
    localparam logic [1:0] REG_R3 = 2'd2;
    localparam logic [1:0] REG_R4 = 2'd3;

    function automatic logic [3:0] reg_onehot(input logic [1:0] n);
        return 4'b0001 << n;
    endfunction

endpackage

// File: rtl/p_readport_intgen.sv
// ---------------------------------------------------------------------------
// p_intgen -- registered parasite interrupt generation.
//   clk, rst_b            : clock, synchronous active-low reset
//   irq_en_r1, irq_en_r4  : IRQ enables for registers 1 and 4
//   nmi_en                : NMI enable (register 3)
//   one_byte_mode         : register 3 one-byte mode
//   avail_r1/r3/r4        : data-available flags for registers 1, 3, 4
//   r3_two_bytes_available: register 3 holds two bytes
//   irq_b, nmi_b          : active-low interrupts, one cycle of latency
// ---------------------------------------------------------------------------
module p_intgen (
    input  logic clk,
    input  logic rst_b,
    input  logic irq_en_r1,
    input  logic irq_en_r4,
    input  logic nmi_en,
    input  logic one_byte_mode,
    input  logic avail_r1,
    input  logic avail_r3,
    input  logic avail_r4,
    input  logic r3_two_bytes_available,
    output logic irq_b,
    output logic nmi_b
);

    logic irq_b_q, irq_b_d;
    logic nmi_b_q, nmi_b_d;

    always_comb begin
        irq_b_d = ~((irq_en_r1 & avail_r1) | (irq_en_r4 & avail_r4));
        // In two-byte mode register 3 only interrupts once a full pair is present.
        nmi_b_d = ~(nmi_en & (one_byte_mode ? avail_r3 : r3_two_bytes_available));
    end

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            irq_b_q <= 1'b1;
            nmi_b_q <= 1'b1;
        end else begin
            irq_b_q <= irq_b_d;
            nmi_b_q <= nmi_b_d;
        end
    end

    assign irq_b = irq_b_q;
    assign nmi_b = nmi_b_q;

endmodule

// File: rtl/p_readport.sv
// ---------------------------------------------------------------------------
// p_readport -- parasite-side read port of the tube.
//   p_phi2, p_rst_b            : clock, synchronous active-low reset
//   p_cs_b, p_rdnw, p_addr     : parasite bus access (even addr = status,
//                                odd addr = data, register n = p_addr[2:1])
//   p_data_available, p_r3_two_bytes_available, one_byte_mode,
//   p_fifo_data, p_not_full    : FIFO status and selected FIFO byte
//   irq_en_r1, irq_en_r4, nmi_en : interrupt enables
//   p_selectData               : one-hot FIFO select during an access
//   p_rdstb_b                  : one-cycle active-low pop after a data read
//   p_dout                     : registered read data
//   p_irq_b, p_nmi_b           : registered active-low interrupts
// ---------------------------------------------------------------------------
module p_readport
    import p_readport_pkg::*;
(
    input  logic       p_phi2,
    input  logic       p_rst_b,
    input  logic       p_cs_b,
    input  logic       p_rdnw,
    input  logic [2:0] p_addr,
    input  logic [3:0] p_data_available,
    input  logic       p_r3_two_bytes_available,
    input  logic       one_byte_mode,
    input  logic [7:0] p_fifo_data,
    input  logic [3:0] p_not_full,
    input  logic       irq_en_r1,
    input  logic       irq_en_r4,
    input  logic       nmi_en,
    output logic [3:0] p_selectData,
    output logic       p_rdstb_b,
    output logic [7:0] p_dout,
    output logic       p_irq_b,
    output logic       p_nmi_b
);

    rp_state_e  state_q, state_d;
    logic [2:0] addr_q, addr_d;
    logic [3:0] sel_q, sel_d;
    logic       rdstb_b_q, rdstb_b_d;
    logic [7:0] dout_q, dout_d;

    logic [1:0] reg_n;
    logic [7:0] status_byte;

    assign reg_n = addr_q[2:1];

    // Register 3 in two-byte mode reports "available" only for a full pair.
    always_comb begin
        status_byte    = 8'h00;
        status_byte[7] = (reg_n == REG_R3 && !one_byte_mode) ? p_r3_two_bytes_available
                                                             : p_data_available[reg_n];
        status_byte[6] = p_not_full[reg_n];
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        rdstb_b_d = 1'b1;
        dout_d    = dout_q;
        case (state_q)
            ST_IDLE: begin
                if (!p_cs_b && p_rdnw) begin
                    addr_d  = p_addr;
                    sel_d   = reg_onehot(p_addr[2:1]);
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                // Track the source every cycle so the last cycle of the access wins.
                dout_d = addr_q[ADDR_DATA_BIT] ? p_fifo_data : status_byte;
                if (p_cs_b) begin
                    if (addr_q[ADDR_DATA_BIT]) begin
                        rdstb_b_d = 1'b0;
                        state_d   = ST_STROBE;
                    end else begin
                        sel_d   = 4'b0000;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_STROBE: begin
                // Chip select is not looked at here; a pending access is taken in IDLE.
                sel_d   = 4'b0000;
                state_d = ST_IDLE;
            end
            default: begin
                sel_d   = 4'b0000;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge p_phi2) begin
        if (!p_rst_b) begin
            state_q   <= ST_IDLE;
            addr_q    <= 3'd0;
            sel_q     <= 4'b0000;
            rdstb_b_q <= 1'b1;
            dout_q    <= 8'h00;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            sel_q     <= sel_d;
            rdstb_b_q <= rdstb_b_d;
            dout_q    <= dout_d;
        end
    end

    assign p_selectData = sel_q;
    assign p_rdstb_b    = rdstb_b_q;
    assign p_dout       = dout_q;

    p_intgen u_intgen (
        .clk                    (p_phi2),
        .rst_b                  (p_rst_b),
        .irq_en_r1              (irq_en_r1),
        .irq_en_r4              (irq_en_r4),
        .nmi_en                 (nmi_en),
        .one_byte_mode          (one_byte_mode),
        .avail_r1               (p_data_available[0]),
        .avail_r3               (p_data_available[2]),
        .avail_r4               (p_data_available[3]),
        .r3_two_bytes_available (p_r3_two_bytes_available),
        .irq_b                  (p_irq_b),
        .nmi_b                  (p_nmi_b)
    );

endmodule

// File: tb/tb_p_readport.sv
// ---------------------------------------------------------------------------
// tb_p_readport -- self-checking bench for p_readport.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_p_readport;
    import p_readport_pkg::*;

    logic       p_phi2 = 1'b0;
    logic       p_rst_b;
    logic       p_cs_b;
    logic       p_rdnw;
    logic [2:0] p_addr;
    logic [3:0] p_data_available;
    logic       p_r3_two_bytes_available;
    logic       one_byte_mode;
    logic [7:0] p_fifo_data;
    logic [3:0] p_not_full;
    logic       irq_en_r1, irq_en_r4, nmi_en;
    logic [3:0] p_selectData;
    logic       p_rdstb_b;
    logic [7:0] p_dout;
    logic       p_irq_b, p_nmi_b;

    always #5 p_phi2 = ~p_phi2;

    p_readport dut (
        .p_phi2                   (p_phi2),
        .p_rst_b                  (p_rst_b),
        .p_cs_b                   (p_cs_b),
        .p_rdnw                   (p_rdnw),
        .p_addr                   (p_addr),
        .p_data_available         (p_data_available),
        .p_r3_two_bytes_available (p_r3_two_bytes_available),
        .one_byte_mode            (one_byte_mode),
        .p_fifo_data              (p_fifo_data),
        .p_not_full               (p_not_full),
        .irq_en_r1                (irq_en_r1),
        .irq_en_r4                (irq_en_r4),
        .nmi_en                   (nmi_en),
        .p_selectData             (p_selectData),
        .p_rdstb_b                (p_rdstb_b),
        .p_dout                   (p_dout),
        .p_irq_b                  (p_irq_b),
        .p_nmi_b                  (p_nmi_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge p_phi2);
        #1;
    endtask

    // Read value the port must return for address a given the current inputs.
    function automatic logic [7:0] spec_byte(input logic [2:0] a, input logic [3:0] av,
                                             input logic two, input logic obm,
                                             input logic [3:0] nf, input logic [7:0] fifo);
        logic [7:0] r;
        int n;
        n = int'(a[2:1]);
        if (a[0]) return fifo;
        r = 8'h00;
        if (n == 2 && !obm) r[7] = two;
        else                r[7] = av[n];
        r[6] = nf[n];
        return r;
    endfunction

    // One random-stimulus cycle; checks the interrupt outputs against the
    // inputs driven this cycle and returns the byte an access to a would see.
    task automatic rcycle(input logic cs, input logic rw, input logic [2:0] a,
                          output logic [7:0] b);
        logic ie, ne;
        p_cs_b                   = cs;
        p_rdnw                   = rw;
        p_addr                   = a;
        p_data_available         = 4'($urandom);
        p_not_full               = 4'($urandom);
        p_r3_two_bytes_available = 1'($urandom);
        one_byte_mode            = 1'($urandom);
        p_fifo_data              = 8'($urandom);
        irq_en_r1                = 1'($urandom);
        irq_en_r4                = 1'($urandom);
        nmi_en                   = 1'($urandom);
        b  = spec_byte(a, p_data_available, p_r3_two_bytes_available, one_byte_mode,
                       p_not_full, p_fifo_data);
        ie = ~((irq_en_r1 & p_data_available[0]) | (irq_en_r4 & p_data_available[3]));
        ne = ~(nmi_en & (one_byte_mode ? p_data_available[2] : p_r3_two_bytes_available));
        tick();
        chk("rnd_irq", 32'(p_irq_b), 32'(ie));
        chk("rnd_nmi", 32'(p_nmi_b), 32'(ne));
    endtask

    typedef struct {
        logic [2:0] addr;
        logic [3:0] avail;
        logic       two;
        logic       obm;
        logic [3:0] nf;
        logic [7:0] exp;
    } svec_t;

    svec_t sv[8];

    initial begin
        logic [7:0] b, dexp;
        logic [3:0] oh;
        logic [2:0] a;
        int L, g;

        sv[0] = '{ADDR_R3_STATUS, 4'b0000, 1'b1, 1'b0, 4'b0000, 8'h80};
        sv[1] = '{ADDR_R3_STATUS, 4'b0100, 1'b0, 1'b1, 4'b0000, 8'h80};
        sv[2] = '{ADDR_R1_STATUS, 4'b0001, 1'b0, 1'b0, 4'b0001, 8'hC0};
        sv[3] = '{ADDR_R2_STATUS, 4'b1101, 1'b1, 1'b0, 4'b1101, 8'h00};
        sv[4] = '{ADDR_R4_STATUS, 4'b1000, 1'b0, 1'b0, 4'b0111, 8'h80};
        sv[5] = '{ADDR_R4_STATUS, 4'b0000, 1'b0, 1'b0, 4'b1000, 8'h40};
        sv[6] = '{ADDR_R3_STATUS, 4'b1011, 1'b1, 1'b1, 4'b1011, 8'h00};
        sv[7] = '{ADDR_R3_STATUS, 4'b0100, 1'b0, 1'b0, 4'b0100, 8'h40};

        // Reset with inputs that would otherwise pull both interrupts low.
        p_rst_b = 1'b0; p_cs_b = 1'b1; p_rdnw = 1'b1; p_addr = 3'd0;
        p_data_available = 4'b0101; p_r3_two_bytes_available = 1'b0;
        one_byte_mode = 1'b1; p_fifo_data = 8'hFF; p_not_full = 4'b1111;
        irq_en_r1 = 1'b1; irq_en_r4 = 1'b0; nmi_en = 1'b1;
        tick(); tick();
        chk("rst_sel",  32'(p_selectData), 32'h0);
        chk("rst_stb",  32'(p_rdstb_b), 32'h1);
        chk("rst_dout", 32'(p_dout), 32'h00);
        chk("rst_irq",  32'(p_irq_b), 32'h1);
        chk("rst_nmi",  32'(p_nmi_b), 32'h1);
        p_rst_b = 1'b1; irq_en_r1 = 1'b0; nmi_en = 1'b0; p_data_available = 4'b0000;
        tick();

        // Data read of addr 1.
        p_fifo_data = 8'hA5; p_addr = ADDR_R1_DATA; p_rdnw = 1'b1; p_cs_b = 1'b0;
        tick();
        chk("rd1_sel_acc", 32'(p_selectData), 32'b0001);
        chk("rd1_stb_acc", 32'(p_rdstb_b), 32'h1);
        tick();
        chk("rd1_dout", 32'(p_dout), 32'hA5);
        tick();
        chk("rd1_sel_hold", 32'(p_selectData), 32'b0001);
        p_cs_b = 1'b1;
        tick();
        chk("rd1_stb_low", 32'(p_rdstb_b), 32'h0);
        chk("rd1_stb_sel", 32'(p_selectData), 32'b0001);
        tick();
        chk("rd1_stb_end", 32'(p_rdstb_b), 32'h1);
        chk("rd1_sel_clr", 32'(p_selectData), 32'b0000);
        tick();
        chk("rd1_stb_once", 32'(p_rdstb_b), 32'h1);

        // Status byte table.
        for (int i = 0; i < 8; i++) begin
            p_addr = sv[i].addr; p_data_available = sv[i].avail;
            p_r3_two_bytes_available = sv[i].two; one_byte_mode = sv[i].obm;
            p_not_full = sv[i].nf; p_fifo_data = 8'h5A; p_cs_b = 1'b0;
            oh = 4'b0001 << sv[i].addr[2:1];
            tick();
            chk("st_sel", 32'(p_selectData), 32'(oh));
            p_cs_b = 1'b1;
            tick();
            chk("st_dout", 32'(p_dout), 32'(sv[i].exp));
            chk("st_sel_clr", 32'(p_selectData), 32'h0);
            chk("st_stb", 32'(p_rdstb_b), 32'h1);
            tick();
            chk("st_nostb", 32'(p_rdstb_b), 32'h1);
        end

        // Write to addr 3 is ignored.
        p_addr = ADDR_R2_DATA; p_rdnw = 1'b0; p_cs_b = 1'b0; p_fifo_data = 8'h11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wr_sel", 32'(p_selectData), 32'h0);
            chk("wr_stb", 32'(p_rdstb_b), 32'h1);
            chk("wr_dout", 32'(p_dout), 32'h40);
        end
        p_cs_b = 1'b1; p_rdnw = 1'b1;
        tick();
        chk("wr_stb_after", 32'(p_rdstb_b), 32'h1);
        chk("wr_dout_after", 32'(p_dout), 32'h40);

        // Back-to-back data reads, second access pending through STROBE.
        p_addr = ADDR_R1_DATA; p_cs_b = 1'b0;
        tick();
        chk("b2b_sel1", 32'(p_selectData), 32'b0001);
        p_cs_b = 1'b1;
        tick();
        chk("b2b_stb1", 32'(p_rdstb_b), 32'h0);
        chk("b2b_stb1_sel", 32'(p_selectData), 32'b0001);
        p_addr = ADDR_R3_DATA; p_cs_b = 1'b0;
        tick();
        chk("b2b_strobe_end", 32'(p_rdstb_b), 32'h1);
        chk("b2b_ignored", 32'(p_selectData), 32'b0000);
        tick();
        chk("b2b_sel2", 32'(p_selectData), 32'b0100);
        chk("b2b_nostb", 32'(p_rdstb_b), 32'h1);
        p_cs_b = 1'b1;
        tick();
        chk("b2b_stb2", 32'(p_rdstb_b), 32'h0);
        chk("b2b_stb2_sel", 32'(p_selectData), 32'b0100);
        tick();
        chk("b2b_stb2_end", 32'(p_rdstb_b), 32'h1);
        chk("b2b_sel_clr", 32'(p_selectData), 32'b0000);

        // Interrupts.
        irq_en_r4 = 1'b1; p_data_available = 4'b0000;
        tick();
        chk("irq_idle", 32'(p_irq_b), 32'h1);
        p_data_available = 4'b1000;
        #1;
        chk("irq_latency", 32'(p_irq_b), 32'h1);
        tick();
        chk("irq_r4", 32'(p_irq_b), 32'h0);
        nmi_en = 1'b1; one_byte_mode = 1'b1; p_data_available = 4'b0100;
        p_r3_two_bytes_available = 1'b0;
        tick();
        chk("nmi_obm", 32'(p_nmi_b), 32'h0);
        chk("irq_clear", 32'(p_irq_b), 32'h1);
        one_byte_mode = 1'b0;
        tick();
        chk("nmi_two", 32'(p_nmi_b), 32'h1);

        // Reset during ACTIVE of a data read of addr 7.
        irq_en_r1 = 1'b1; p_data_available = 4'b0101; one_byte_mode = 1'b1;
        p_fifo_data = 8'h3C; p_addr = ADDR_R4_DATA; p_cs_b = 1'b0;
        tick();
        chk("ra_sel", 32'(p_selectData), 32'b1000);
        tick();
        chk("ra_dout", 32'(p_dout), 32'h3C);
        chk("ra_irq_pre", 32'(p_irq_b), 32'h0);
        p_rst_b = 1'b0;
        tick();
        chk("ra_sel_rst", 32'(p_selectData), 32'h0);
        chk("ra_stb_rst", 32'(p_rdstb_b), 32'h1);
        chk("ra_dout_rst", 32'(p_dout), 32'h00);
        chk("ra_irq_rst", 32'(p_irq_b), 32'h1);
        chk("ra_nmi_rst", 32'(p_nmi_b), 32'h1);
        p_cs_b = 1'b1; p_rst_b = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("ra_nostb", 32'(p_rdstb_b), 32'h1);
            chk("ra_nosel", 32'(p_selectData), 32'h0);
            chk("ra_dout_hold", 32'(p_dout), 32'h00);
        end

        // Randomized transactions against the access-level model.
        dexp = 8'h00;
        for (int t = 0; t < 120; t++) begin
            a  = 3'($urandom_range(0, 7));
            L  = int'($urandom_range(1, 4));
            oh = 4'b0001 << a[2:1];
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < L; j++) begin
                    rcycle(1'b0, 1'b0, a, b);
                    chk("rnd_wr_sel", 32'(p_selectData), 32'h0);
                    chk("rnd_wr_stb", 32'(p_rdstb_b), 32'h1);
                    chk("rnd_wr_dout", 32'(p_dout), 32'(dexp));
                end
            end else begin
                rcycle(1'b0, 1'b1, a, b);
                chk("rnd_acc_sel", 32'(p_selectData), 32'(oh));
                chk("rnd_acc_stb", 32'(p_rdstb_b), 32'h1);
                for (int j = 1; j <= L; j++) begin
                    rcycle(j == L, 1'b1, a, b);
                    dexp = b;
                    chk("rnd_dout", 32'(p_dout), 32'(dexp));
                    chk("rnd_sel", 32'(p_selectData), (j < L || a[0]) ? 32'(oh) : 32'h0);
                    chk("rnd_stb", 32'(p_rdstb_b), (j == L && a[0]) ? 32'h0 : 32'h1);
                end
                if (a[0]) begin
                    rcycle(1'b1, 1'($urandom), 3'($urandom), b);
                    chk("rnd_stb_end", 32'(p_rdstb_b), 32'h1);
                    chk("rnd_sel_end", 32'(p_selectData), 32'h0);
                    chk("rnd_dout_end", 32'(p_dout), 32'(dexp));
                end
            end
            g = int'($urandom_range(1, 3));
            for (int j = 0; j < g; j++) begin
                rcycle(1'b1, 1'($urandom), 3'($urandom), b);
                chk("rnd_gap_sel", 32'(p_selectData), 32'h0);
                chk("rnd_gap_stb", 32'(p_rdstb_b), 32'h1);
                chk("rnd_gap_dout", 32'(p_dout), 32'(dexp));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
